// File: rtl/lcd_char_ctrl.sv
// Character-LCD controller for HD44780-compatible panels on an 8-bit, write-only bus.
// A ROWS x COLS shadow buffer is written by the host. After reset the controller
// powers up and initialises the panel. From then on it redraws the whole panel
// whenever the buffer is marked dirty. Raw panel commands enter through a
// valid/ready port.
//
// Handshake: a command is transferred on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_data is sampled on that edge only. cmd_ready is 1
// exactly while the FSM is in IDLE and does not depend on cmd_valid.
module lcd_char_ctrl #(
  parameter int ROWS     = 2,
  parameter int COLS     = 16,
  parameter int EN_DIV   = 64,
  parameter int PWR_WAIT = 65536,
  parameter int CLR_WAIT = 2048,
  parameter int AW       = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          cmd_valid,
  input  logic [7:0]    cmd_data,
  output logic          cmd_ready,
  output logic          busy,
  output logic [7:0]    lcd_dat,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [2:0]    dbg_state
);

  localparam int N    = ROWS * COLS;
  localparam int IW   = $clog2(N);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW  = $clog2(COLS);
  localparam int MAXC = (PWR_WAIT > EN_DIV) ?
                        ((PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT) :
                        ((EN_DIV > CLR_WAIT) ? EN_DIV : CLR_WAIT);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]  EN_LAST  = CW'(EN_DIV - 1);
  localparam logic [CW-1:0]  CLR_LAST = CW'(CLR_WAIT - 1);
  localparam logic [CW-1:0]  PWR_LAST = CW'(PWR_WAIT - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);

  typedef enum logic [2:0] {
    ST_PWR  = 3'd0,
    ST_INIT = 3'd1,
    ST_IDLE = 3'd2,
    ST_CMD  = 3'd3,
    ST_ADDR = 3'd4,
    ST_DATA = 3'd5
  } state_t;

  // A: setup with en low, B: en high, C: hold with en low, W: clear/home wait
  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2,
    PH_W = 2'd3
  } phase_t;

  state_t         state, state_n;
  phase_t         phase, phase_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     init_idx, init_idx_n;
  logic [RW-1:0]  row, row_n;
  logic [CLW-1:0] col, col_n;
  logic           dirty, dirty_n;
  logic [7:0]     dat_q, dat_n;
  logic           rs_q, rs_n;
  logic           sending;
  logic           xfer_done;
  logic           needs_clr;
  logic           fetch;
  logic           wr_ok;
  logic [IW-1:0]  rd_idx;
  logic [7:0]     mem [N];

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Set-DDRAM-address command for the first cell of row r
  function automatic logic [7:0] row_addr(input logic [RW-1:0] r);
    case (int'(r))
      0:       return 8'h80;
      1:       return 8'hC0;
      2:       return 8'h80 | 8'(COLS);
      default: return 8'h80 | 8'(64 + COLS);
    endcase
  endfunction

  assign wr_ok     = wr_en && (int'(wr_addr) < N);
  assign sending   = (state == ST_INIT) || (state == ST_CMD) ||
                     (state == ST_ADDR) || (state == ST_DATA);
  assign needs_clr = !rs_q && (dat_q >= 8'h01) && (dat_q <= 8'h03);

  assign lcd_en    = sending && (phase == PH_B);
  assign lcd_dat   = dat_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign busy      = (state != ST_IDLE);
  assign cmd_ready = (state == ST_IDLE);
  assign dbg_state = state;

  // Shadow frame buffer: not reset, out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[IW-1:0]] <= wr_data;
  end

  // State, bus-phase timer, redraw position, dirty flag and bus byte registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_PWR;
      phase    <= PH_A;
      cnt      <= '0;
      init_idx <= '0;
      row      <= '0;
      col      <= '0;
      dirty    <= 1'b1;
      dat_q    <= 8'h00;
      rs_q     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      init_idx <= init_idx_n;
      row      <= row_n;
      col      <= col_n;
      dirty    <= dirty_n;
      dat_q    <= dat_n;
      rs_q     <= rs_n;
    end
  end

  // Bus-phase sequencing, next-state logic and loading of the next byte
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    init_idx_n = init_idx;
    row_n      = row;
    col_n      = col;
    dirty_n    = dirty;
    dat_n      = dat_q;
    rs_n       = rs_q;
    xfer_done  = 1'b0;
    fetch      = 1'b0;
    rd_idx     = '0;

    if (sending) begin
      case (phase)
        PH_A: begin
          if (cnt == EN_LAST) begin
            phase_n = PH_B;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        PH_B: begin
          if (cnt == EN_LAST) begin
            phase_n = PH_C;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        PH_C: begin
          if (cnt == EN_LAST) begin
            if (needs_clr) begin
              phase_n = PH_W;
              cnt_n   = '0;
            end else begin
              xfer_done = 1'b1;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == CLR_LAST) xfer_done = 1'b1;
          else                 cnt_n = cnt + CW'(1);
        end
      endcase
    end

    case (state)
      ST_PWR: begin
        if (cnt == PWR_LAST) begin
          state_n    = ST_INIT;
          init_idx_n = 2'd0;
          phase_n    = PH_A;
          cnt_n      = '0;
          dat_n      = init_byte(2'd0);
          rs_n       = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_INIT: begin
        if (xfer_done) begin
          if (init_idx == 2'd3) begin
            state_n = ST_IDLE;
          end else begin
            init_idx_n = init_idx + 2'd1;
            phase_n    = PH_A;
            cnt_n      = '0;
            dat_n      = init_byte(init_idx + 2'd1);
            rs_n       = 1'b0;
          end
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          state_n = ST_CMD;
          phase_n = PH_A;
          cnt_n   = '0;
          dat_n   = cmd_data;
          rs_n    = 1'b0;
        end else if (dirty) begin
          state_n = ST_ADDR;
          row_n   = '0;
          dirty_n = 1'b0;
          phase_n = PH_A;
          cnt_n   = '0;
          dat_n   = row_addr('0);
          rs_n    = 1'b0;
        end
      end
      ST_CMD: begin
        if (xfer_done) state_n = ST_IDLE;
      end
      ST_ADDR: begin
        if (xfer_done) begin
          state_n = ST_DATA;
          col_n   = '0;
          fetch   = 1'b1;
          phase_n = PH_A;
          cnt_n   = '0;
          rs_n    = 1'b1;
        end
      end
      ST_DATA: begin
        if (xfer_done) begin
          if (col == COL_LAST) begin
            if (row == ROW_LAST) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_ADDR;
              row_n   = row + RW'(1);
              phase_n = PH_A;
              cnt_n   = '0;
              dat_n   = row_addr(row + RW'(1));
              rs_n    = 1'b0;
            end
          end else begin
            col_n   = col + CLW'(1);
            fetch   = 1'b1;
            phase_n = PH_A;
            cnt_n   = '0;
            rs_n    = 1'b1;
          end
        end
      end
      default: state_n = ST_PWR;
    endcase

    // A character is latched when its transfer starts; a write landing on the
    // same cell in that very cycle is forwarded so the newest value is shown.
    if (fetch) begin
      rd_idx = IW'(int'(row_n) * COLS + int'(col_n));
      if (wr_ok && (wr_addr[IW-1:0] == rd_idx)) dat_n = wr_data;
      else                                      dat_n = mem[rd_idx];
    end

    // A host write always wins over the clear taken when a redraw starts
    if (wr_ok) dirty_n = 1'b1;
  end

endmodule
